alu_issue_ctrl: RTL and testbench

- Initiator side of the ALU operand/control interface.
- Accepts a decode-stage request (ALUOp, funct, two register operands) over a valid/ready handshake and decodes it to the 4-bit ALU control code.
- Drives the combinational ALU's src1/src2/ctrl inputs stably for a programmable number of cycles, then captures result/zero.
- Returns the captured values to the writeback side over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: accepts decode requests, holds ALU inputs for
// EXEC_CYCLES cycles, captures result/zero and returns them. Optional: `ALU_ISSUE_ILLEGAL_CHK_EN.
module alu_issue_ctrl #(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        aluop_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [3:0]        alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_zero_o,
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
    output logic              rsp_illegal_o,
`endif
    output logic [3:0]        rsp_ctrl_o
);

    // state   | meaning
    // IDLE    | waiting for a request, req_ready_o high
    // EXEC    | ALU inputs held, counter running down
    // RESP    | captured response offered to writeback
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_ILL = 4'b1111;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       load;
    logic       capture;
    logic [3:0] dec_ctrl;

    function automatic logic [3:0] decode(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] code;
        case (aluop)
            2'b00:   code = CTRL_ADD;
            2'b01:   code = CTRL_SUB;
            2'b11:   code = CTRL_SLT;
            default: begin
                case (funct)
                    6'b100000: code = CTRL_ADD;
                    6'b100010: code = CTRL_SUB;
                    6'b100100: code = CTRL_AND;
                    6'b100101: code = CTRL_OR;
                    6'b101010: code = CTRL_SLT;
                    default:   code = CTRL_ILL;
                endcase
            end
        endcase
        return code;
    endfunction

    assign dec_ctrl = decode(aluop_i, funct_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Ready is gated with reset so nothing can look accepted while reset is held.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        load        = 1'b0;
        capture     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_o = rst_i;
                if (req_valid_i) begin
                    load      = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                req_ready_o = rsp_ready_i & rst_i;
                if (rsp_ready_i) begin
                    if (req_valid_i) begin
                        load      = 1'b1;
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = ST_EXEC;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ALU inputs are only written on accept, so they stay put through EXEC and after.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            alu_src1_o <= '0;
            alu_src2_o <= '0;
            alu_ctrl_o <= 4'd0;
        end else if (load) begin
            alu_src1_o <= rs_data_i;
            alu_src2_o <= rt_data_i;
            alu_ctrl_o <= dec_ctrl;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp_result_o  <= '0;
            rsp_zero_o    <= 1'b0;
            rsp_ctrl_o    <= 4'd0;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
            rsp_illegal_o <= 1'b0;
`endif
        end else if (capture) begin
            rsp_ctrl_o <= alu_ctrl_o;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
            if (alu_ctrl_o == CTRL_ILL) begin
                rsp_result_o  <= '0;
                rsp_zero_o    <= 1'b1;
                rsp_illegal_o <= 1'b1;
            end else begin
                rsp_result_o  <= alu_result_i;
                rsp_zero_o    <= alu_zero_i;
                rsp_illegal_o <= 1'b0;
            end
`else
            rsp_result_o <= alu_result_i;
            rsp_zero_o   <= alu_zero_i;
`endif
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with EXEC_CYCLES=1, one with EXEC_CYCLES=3,
// each driving a small behavioural ALU.
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // EXEC_CYCLES=1 instance
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_zero, alu_zero;
    logic [1:0]  aluop = 2'd0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] rs = '0, rt = '0, src1, src2, alu_res, rsp_result;
    logic [3:0]  ctrl, rsp_ctrl;
    // EXEC_CYCLES=3 instance
    logic        req_valid3 = 1'b0, req_ready3, rsp_valid3, rsp_ready3 = 1'b0, rsp_zero3, alu_zero3;
    logic [1:0]  aluop3 = 2'd0;
    logic [5:0]  funct3 = 6'd0;
    logic [31:0] rs3 = '0, rt3 = '0, src1_3, src2_3, alu_res3, rsp_result3;
    logic [3:0]  ctrl3, rsp_ctrl3;
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
    logic        rsp_illegal, rsp_illegal3;
`endif

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_res   = alu_f(ctrl, src1, src2);
    assign alu_zero  = (alu_res == 32'd0);
    assign alu_res3  = alu_f(ctrl3, src1_3, src2_3);
    assign alu_zero3 = (alu_res3 == 32'd0);

    alu_issue_ctrl #(.DATA_W(32), .EXEC_CYCLES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .aluop_i(aluop), .funct_i(funct), .rs_data_i(rs), .rt_data_i(rt),
        .alu_src1_o(src1), .alu_src2_o(src2), .alu_ctrl_o(ctrl),
        .alu_result_i(alu_res), .alu_zero_i(alu_zero),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
        .rsp_illegal_o(rsp_illegal),
`endif
        .rsp_ctrl_o(rsp_ctrl)
    );

    alu_issue_ctrl #(.DATA_W(32), .EXEC_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3),
        .aluop_i(aluop3), .funct_i(funct3), .rs_data_i(rs3), .rt_data_i(rt3),
        .alu_src1_o(src1_3), .alu_src2_o(src2_3), .alu_ctrl_o(ctrl3),
        .alu_result_i(alu_res3), .alu_zero_i(alu_zero3),
        .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3),
        .rsp_result_o(rsp_result3), .rsp_zero_o(rsp_zero3),
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
        .rsp_illegal_o(rsp_illegal3),
`endif
        .rsp_ctrl_o(rsp_ctrl3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request from a negedge; returns at the negedge after the accepting edge.
    task automatic do_req(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        aluop = op; funct = fn; rs = a; rt = b;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic run_vec(input string tag, input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] exp_ctrl,
                           input logic [31:0] exp_res, input logic exp_zero, input logic exp_ill);
        int n;
        do_req(op, fn, a, b);
        check({tag, "_alu_ctrl"}, {28'd0, ctrl}, {28'd0, exp_ctrl});
        wait_rsp(n);
        check({tag, "_latency"}, n + 1, 32'd2);
        check({tag, "_rsp_ctrl"}, {28'd0, rsp_ctrl}, {28'd0, exp_ctrl});
        check({tag, "_rsp_result"}, rsp_result, exp_res);
        check({tag, "_rsp_zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
        check({tag, "_rsp_illegal"}, {31'd0, rsp_illegal}, {31'd0, exp_ill});
`else
        if (exp_ill) check({tag, "_fwd_ctrl"}, {28'd0, rsp_ctrl}, 32'hF);
`endif
        finish_rsp(tag);
    endtask

    initial begin
        int n;
        logic [31:0] s1, s2;
        logic [3:0]  c3;

        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_src1", src1, 32'd0);
        check("rst_ctrl", {28'd0, ctrl}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        rst = 1'b1;
        #1;
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        run_vec("add_funct", 2'b10, 6'b100000, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0);
        run_vec("sub_equal", 2'b01, 6'b000000, 32'h1234, 32'h1234, 4'b0110, 32'd0, 1'b1, 1'b0);
        run_vec("add_wrap", 2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 1'b0);
        run_vec("illegal", 2'b10, 6'b000000, 32'd9, 32'd4, 4'b1111, 32'd0, 1'b1, 1'b1);

        // SLT with writeback stalled, then back-to-back AND on the releasing edge
        do_req(2'b10, 6'b101010, 32'd3, 32'd9);
        wait_rsp(n);
        check("slt_latency", n + 1, 32'd2);
        req_valid = 1'b1; aluop = 2'b10; funct = 6'b100100; rs = 32'hF0F0; rt = 32'h0FF0;
        for (int i = 0; i < 4; i++) begin
            check("slt_hold_result", rsp_result, 32'd1);
            check("slt_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("slt_hold_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        check("slt_rsp_ctrl", {28'd0, rsp_ctrl}, 32'h7);
        rsp_ready = 1'b1;
        #1;
        check("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("b2b_valid_low", {31'd0, rsp_valid}, 32'd0);
        check("b2b_alu_ctrl", {28'd0, ctrl}, 32'h0);
        check("b2b_src1", src1, 32'hF0F0);
        wait_rsp(n);
        check("b2b_latency", n + 1, 32'd2);
        check("b2b_result", rsp_result, 32'h00F0);
        finish_rsp("b2b");
        check("keep_src2", src2, 32'h0FF0);

        // SLT via ALUOp=11 with writeback ready already high during EXEC
        do_req(2'b11, 6'b000000, 32'd9, 32'd3);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("slt11_valid", {31'd0, rsp_valid}, 32'd1);
        check("slt11_result", rsp_result, 32'd0);
        check("slt11_zero", {31'd0, rsp_zero}, 32'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("slt11_done", {31'd0, rsp_valid}, 32'd0);

        // reset while a response is pending
        do_req(2'b00, 6'b000000, 32'd1, 32'd1);
        wait_rsp(n);
        rst = 1'b0;
        #1;
        check("rst_resp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_resp_result", rsp_result, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // reset mid-EXEC
        do_req(2'b00, 6'b000000, 32'd100, 32'd200);
        rst = 1'b0;
        #1;
        check("rst_exec_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_exec_ready", {31'd0, req_ready}, 32'd0);
        check("rst_exec_src1", src1, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        run_vec("post_rst_add", 2'b00, 6'b000000, 32'd10, 32'd20, 4'b0010, 32'd30, 1'b0, 1'b0);

        // EXEC_CYCLES=3 instance: OR with held inputs
        req_valid3 = 1'b1; aluop3 = 2'b10; funct3 = 6'b100101; rs3 = 32'hA000; rt3 = 32'h000B;
        @(posedge clk);
        @(negedge clk);
        req_valid3 = 1'b0;
        rs3 = 32'hDEAD; rt3 = 32'hBEEF;
        s1 = src1_3; s2 = src2_3; c3 = ctrl3;
        check("e3_src1", s1, 32'hA000);
        check("e3_src2", s2, 32'h000B);
        check("e3_ctrl", {28'd0, c3}, 32'h1);
        n = 0;
        while (!rsp_valid3 && n < 20) begin
            check("e3_src1_stable", src1_3, 32'hA000);
            check("e3_src2_stable", src2_3, 32'h000B);
            check("e3_ctrl_stable", {28'd0, ctrl3}, 32'h1);
            @(negedge clk);
            n++;
        end
        check("e3_latency", n + 1, 32'd4);
        check("e3_result", rsp_result3, 32'hA00B);
        check("e3_rsp_ctrl", {28'd0, rsp_ctrl3}, 32'h1);
        rsp_ready3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready3 = 1'b0;
        check("e3_done", {31'd0, rsp_valid3}, 32'd0);
        check("e3_ready", {31'd0, req_ready3}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
